wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback pipeline stage between the MEM stage and the register file's single write port.
- Registers ALU results; waits for load data from the data-memory response channel with variable latency.
- Aligns, sign- or zero-extends the load data, then drives wd/w_addr/wdata to the regfile.
- While a load is outstanding, stalls upstream via wb_busy; handles flush of an in-flight load.

Parameters:
- DATA_W, 32, register/data width
- REG_AW, 5, register address width
- TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_wd  in  1  instruction writes a register
- mem_waddr  in  REG_AW  destination register
- mem_wdata  in  DATA_W  ALU result (non-load)
- mem_load  in  1  instruction is a load
- mem_load_type  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW; others reserved
- mem_addr_lo  in  2  load address bits [1:0]
- dm_rdata  in  DATA_W  data-memory read word
- dm_data_ok  in  1  dm_rdata valid this cycle
- stall_i  in  1  MEM stage stalled; capture a bubble
- flush_i  in  1  discard current/outstanding instruction
- wd  out  1  regfile write enable
- w_addr  out  REG_AW  regfile write address
- wdata  out  DATA_W  regfile write data
- wb_busy  out  1  upstream must hold (WAIT or DRAIN)
- misalign_o  out  1  one-cycle pulse: misaligned load dropped
- bus_err_o  out  1  one-cycle pulse: load timed out

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state RUN, counter 0.
- All outputs are registered. A write appears on wd/w_addr/wdata the cycle after capture or completion. The regfile bypass relies on this.
- wd is a single-cycle pulse per retired instruction. w_addr/wdata hold their last value when wd=0.
- wb_busy = (state==WAIT || state==DRAIN), combinational from state.
- State RUN:
  - flush_i → bubble (wd=0).
  - else stall_i or !mem_valid → bubble.
  - else non-load → wd<=mem_wd, w_addr<=mem_waddr, wdata<=mem_wdata.
  - else load with dm_data_ok=1 in the same cycle → complete immediately (see extraction).
  - else load → latch waddr/wd/type/addr_lo, wd<=0, counter<=0, go WAIT.
- State WAIT (mem inputs ignored):
  - flush_i and dm_data_ok together → drop data, go RUN.
  - flush_i alone → go DRAIN.
  - dm_data_ok → complete, go RUN.
  - counter==TIMEOUT-1 → bus_err_o pulse, wd=0, go RUN.
  - otherwise counter++.
- State DRAIN: wd=0, flush_i ignored. The next dm_data_ok is discarded, then go RUN. No timeout in DRAIN.
- Extraction (little-endian, b = addr_lo):
  - LB/LBU: byte at bits [8b+7:8b], sign- or zero-extended.
  - LH/LHU: halfword at addr_lo[1].
  - LW: full word.
- Misaligned loads (LH/LHU with b[0]=1, LW with b≠0, or reserved type): wd=0, misalign_o pulse, no write.
- Latched wd=0 on a load (e.g. load to r0 filtered upstream): completion still consumes the response, wd stays 0.
- Reset mid-WAIT returns to RUN. The late response is not tracked; system reset covers memory too.

Decomposition:
- Shared package (cpu_defs):
  - load type codes LT_LB..LT_LW
  - state encoding RUN=0, WAIT=1, DRAIN=2
  - DATA_W/REG_AW constants
- Sub-module load_align: purely combinational (type, addr_lo, rdata) → (data, misalign). This is reusable by the LSU.

Test Plan:
- ALU op: mem_valid=1, mem_wd=1, waddr=5, wdata=0x1234 → next cycle wd=1, w_addr=5, wdata=0x1234; following cycle wd=0.
- LB, b=2, dm_rdata=0x0080_0000 with data_ok 3 cycles after capture → wb_busy=1 for 3 cycles, then wd=1, wdata=0xFFFF_FF80.
- LHU, b=2, dm_rdata=0xBEEF_0000, data_ok same cycle as capture → no WAIT, wd=1, wdata=0x0000_BEEF.
- LW with b=1 → misalign_o pulses once at completion, wd stays 0.
- LW captured, then flush_i in WAIT before data_ok → DRAIN. Next dm_data_ok=0xDEAD is ignored; next ALU op writes correctly.
- LW with no data_ok → bus_err_o pulses exactly TIMEOUT cycles after capture, state RUN, wd=0. Assert rst=0 mid-WAIT → outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load type codes, FSM state
// encoding and default datapath widths.
package wb_stage_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    // Width of the WAIT-state timeout counter.
    localparam int CNT_W = 8;

    // Load type codes as presented on mem_load_type; 5..7 are reserved.
    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [2:0] LT_LW  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB instruction bus, with the wb_busy hold signal going back upstream.
interface wb_stage_if
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW
);
    logic              mem_valid;
    logic              mem_wd;
    logic [REG_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_load;
    logic [2:0]        mem_load_type;
    logic [1:0]        mem_addr_lo;
    logic              wb_busy;

    modport master (
        output mem_valid, mem_wd, mem_waddr, mem_wdata,
               mem_load, mem_load_type, mem_addr_lo,
        input  wb_busy
    );

    modport slave (
        input  mem_valid, mem_wd, mem_waddr, mem_wdata,
               mem_load, mem_load_type, mem_addr_lo,
        output wb_busy
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian load extraction: selects the addressed byte/halfword/word,
// sign- or zero-extends it and flags misaligned or reserved accesses.
// Purely combinational so the LSU can reuse it.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    // Shift the addressed lane down to bit 0, then extend per load type.
    always_comb begin
        byte_sh  = rdata >> {addr_lo, 3'b000};
        half_sh  = rdata >> {addr_lo[1], 4'b0000};
        lane_b   = byte_sh[7:0];
        lane_h   = half_sh[15:0];
        data     = '0;
        misalign = 1'b0;
        case (load_type)
            LT_LB:  data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            LT_LBU: data = {{(DATA_W-8){1'b0}}, lane_b};
            LT_LH: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            end
            LT_LHU: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data = {{(DATA_W-16){1'b0}}, lane_h};
            end
            LT_LW: begin
                if (addr_lo != 2'b00) misalign = 1'b1;
                else                  data = rdata;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results, waits for variable-latency load
// data, aligns/extends it and drives the single regfile write port.
// All outputs except wb_busy are registered so the regfile bypass sees each
// write exactly one cycle after capture or completion.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int REG_AW  = WB_REG_AW,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    wb_stage_if.slave         mem,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_data_ok,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              wd,
    output logic [REG_AW-1:0] w_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_e         state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    // Load context held while the response is outstanding.
    logic              ld_wd_p1;
    logic [REG_AW-1:0] ld_waddr_p1;
    logic [2:0]        ld_type_p1;
    logic [1:0]        ld_lo_p1;
    logic              capture;

    logic [2:0]        al_type;
    logic [1:0]        al_lo;
    logic [DATA_W-1:0] al_data;
    logic              al_mis;
    logic              done_wd;
    logic [REG_AW-1:0] done_addr;

    logic              wd_n;
    logic [REG_AW-1:0] w_addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              mis_n;
    logic              err_n;

    // In RUN the load completes from live MEM fields, otherwise from the latch.
    assign al_type   = (state_q == ST_RUN) ? mem.mem_load_type : ld_type_p1;
    assign al_lo     = (state_q == ST_RUN) ? mem.mem_addr_lo   : ld_lo_p1;
    assign done_wd   = (state_q == ST_RUN) ? mem.mem_wd        : ld_wd_p1;
    assign done_addr = (state_q == ST_RUN) ? mem.mem_waddr     : ld_waddr_p1;

    assign mem.wb_busy = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    load_align #(.DATA_W(DATA_W)) u_align (
        .load_type (al_type),
        .addr_lo   (al_lo),
        .rdata     (dm_rdata),
        .data      (al_data),
        .misalign  (al_mis)
    );

    // Next-state and next-output decode for the RUN/WAIT/DRAIN controller.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        wd_n     = 1'b0;
        w_addr_n = w_addr;
        wdata_n  = wdata;
        mis_n    = 1'b0;
        err_n    = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_i || stall_i || !mem.mem_valid) begin
                    // bubble
                end else if (!mem.mem_load) begin
                    if (mem.mem_wd) begin
                        wd_n     = 1'b1;
                        w_addr_n = mem.mem_waddr;
                        wdata_n  = mem.mem_wdata;
                    end
                end else if (dm_data_ok) begin
                    if (al_mis) begin
                        mis_n = 1'b1;
                    end else if (done_wd) begin
                        wd_n     = 1'b1;
                        w_addr_n = done_addr;
                        wdata_n  = al_data;
                    end
                end else begin
                    capture = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i && dm_data_ok) begin
                    state_n = ST_RUN;
                end else if (flush_i) begin
                    state_n = ST_DRAIN;
                end else if (dm_data_ok) begin
                    state_n = ST_RUN;
                    if (al_mis) begin
                        mis_n = 1'b1;
                    end else if (done_wd) begin
                        wd_n     = 1'b1;
                        w_addr_n = done_addr;
                        wdata_n  = al_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_n   = 1'b1;
                    state_n = ST_RUN;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dm_data_ok) state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    // Controller state and registered regfile/pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            wd         <= 1'b0;
            w_addr     <= '0;
            wdata      <= '0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            wd         <= wd_n;
            w_addr     <= w_addr_n;
            wdata      <= wdata_n;
            misalign_o <= mis_n;
            bus_err_o  <= err_n;
        end
    end

    // Latch the outstanding load's destination and alignment context.
    always_ff @(posedge clk) begin
        if (capture) begin
            ld_wd_p1    <= mem.mem_wd;
            ld_waddr_p1 <= mem.mem_waddr;
            ld_type_p1  <= mem.mem_load_type;
            ld_lo_p1    <= mem.mem_addr_lo;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, multi-cycle corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dm_rdata;
    logic        dm_data_ok, stall_i, flush_i;
    logic        wd, misalign_o, bus_err_o;
    logic [4:0]  w_addr;
    logic [31:0] wdata;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .REG_AW(5)) mif ();

    wb_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mif),
        .dm_rdata   (dm_rdata),
        .dm_data_ok (dm_data_ok),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wd         (wd),
        .w_addr     (w_addr),
        .wdata      (wdata),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o)
    );

    typedef struct {
        string       name;
        logic        valid, stall, flush, wdf;
        logic [4:0]  waddr;
        logic [31:0] wdat;
        logic        load;
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic        ok;
        logic        exp_wd;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(string nm, logic v, logic st, logic fl, logic wf,
                                logic [4:0] wa, logic [31:0] wdt, logic ld,
                                logic [2:0] lt, logic [1:0] lo, logic [31:0] rd,
                                logic ok, logic ewd, logic [4:0] ea,
                                logic [31:0] ed, logic emis);
        vec_t r;
        r.name = nm; r.valid = v; r.stall = st; r.flush = fl; r.wdf = wf;
        r.waddr = wa; r.wdat = wdt; r.load = ld; r.lt = lt; r.lo = lo;
        r.rdata = rd; r.ok = ok; r.exp_wd = ewd; r.exp_addr = ea;
        r.exp_data = ed; r.exp_mis = emis;
        return r;
    endfunction

    // Reference load extraction from the byte-lane rules, in plain arithmetic.
    function automatic void ref_load(input int t, input int lo, input logic [31:0] rd,
                                     output logic [31:0] v, output bit mis);
        int unsigned w, b, h;
        w = rd;
        b = (w / (1 << (8 * lo))) % 256;
        h = (w / (1 << (16 * (lo / 2)))) % 65536;
        v = 0;
        mis = 0;
        case (t)
            0: v = (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            1: v = b;
            2: if (lo % 2 != 0) mis = 1; else v = (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3: if (lo % 2 != 0) mis = 1; else v = h;
            4: if (lo != 0) mis = 1; else v = w;
            default: mis = 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.mem_valid = 0; mif.mem_wd = 0; mif.mem_waddr = 0; mif.mem_wdata = 0;
        mif.mem_load = 0; mif.mem_load_type = 0; mif.mem_addr_lo = 0;
        dm_rdata = 0; dm_data_ok = 0; stall_i = 0; flush_i = 0;
    endtask

    // Random MEM traffic while the stage is busy; it must be ignored.
    task automatic junk();
        mif.mem_valid = 1'($urandom); mif.mem_wd = 1'($urandom);
        mif.mem_waddr = 5'($urandom); mif.mem_wdata = $urandom;
        mif.mem_load = 1'($urandom); mif.mem_load_type = 3'($urandom);
        mif.mem_addr_lo = 2'($urandom); stall_i = 1'($urandom);
        dm_rdata = $urandom; dm_data_ok = 0; flush_i = 0;
    endtask

    task automatic drive_run(input logic v, input logic st, input logic fl, input logic wf,
                             input logic [4:0] wa, input logic [31:0] wdt, input logic ld,
                             input logic [2:0] lt, input logic [1:0] lo,
                             input logic [31:0] rd, input logic ok);
        mif.mem_valid = v; stall_i = st; flush_i = fl; mif.mem_wd = wf;
        mif.mem_waddr = wa; mif.mem_wdata = wdt; mif.mem_load = ld;
        mif.mem_load_type = lt; mif.mem_addr_lo = lo; dm_rdata = rd; dm_data_ok = ok;
    endtask

    task automatic check_out(input string nm, input logic ewd, input logic [4:0] ea,
                             input logic [31:0] ed, input logic emis, input logic eerr,
                             input logic ebusy);
        chk({nm, " wd"}, wd, ewd);
        if (ewd) begin
            chk({nm, " w_addr"}, w_addr, ea);
            chk({nm, " wdata"}, wdata, ed);
            last_addr = ea;
            last_data = ed;
        end else begin
            chk({nm, " w_addr hold"}, w_addr, last_addr);
            chk({nm, " wdata hold"}, wdata, last_data);
        end
        chk({nm, " misalign"}, misalign_o, emis);
        chk({nm, " bus_err"}, bus_err_o, eerr);
        chk({nm, " wb_busy"}, mif.wb_busy, ebusy);
    endtask

    initial begin
        logic [31:0] ev;
        bit          emis;

        vecs[0]  = mk("alu",         1,0,0,1, 5, 32'h1234, 0,0,0, 0,           0, 1, 5, 32'h1234, 0);
        vecs[1]  = mk("alu nowd",    1,0,0,0, 9, 32'hFFFF, 0,0,0, 0,           1, 0, 0, 0, 0);
        vecs[2]  = mk("stall",       1,1,0,1, 3, 32'hAAAA, 0,0,0, 0,           0, 0, 0, 0, 0);
        vecs[3]  = mk("flush",       1,0,1,1, 3, 32'hAAAA, 0,0,0, 0,           0, 0, 0, 0, 0);
        vecs[4]  = mk("novalid",     0,0,0,1, 3, 32'hAAAA, 0,0,0, 0,           0, 0, 0, 0, 0);
        vecs[5]  = mk("lb b0",       1,0,0,1, 1, 0, 1,LT_LB, 0, 32'h1234_567F, 1, 1, 1, 32'h0000_007F, 0);
        vecs[6]  = mk("lb b3",       1,0,0,1, 2, 0, 1,LT_LB, 3, 32'h8012_3456, 1, 1, 2, 32'hFFFF_FF80, 0);
        vecs[7]  = mk("lbu b1",      1,0,0,1, 3, 0, 1,LT_LBU,1, 32'h0000_A500, 1, 1, 3, 32'h0000_00A5, 0);
        vecs[8]  = mk("lh b2",       1,0,0,1, 4, 0, 1,LT_LH, 2, 32'h8001_1234, 1, 1, 4, 32'hFFFF_8001, 0);
        vecs[9]  = mk("lhu b2",      1,0,0,1, 6, 0, 1,LT_LHU,2, 32'hBEEF_0000, 1, 1, 6, 32'h0000_BEEF, 0);
        vecs[10] = mk("lhu b0",      1,0,0,1, 8, 0, 1,LT_LHU,0, 32'h1234_8000, 1, 1, 8, 32'h0000_8000, 0);
        vecs[11] = mk("lw b0",       1,0,0,1,10, 0, 1,LT_LW, 0, 32'hCAFE_F00D, 1, 1,10, 32'hCAFE_F00D, 0);
        vecs[12] = mk("lw b2 mis",   1,0,0,1,11, 0, 1,LT_LW, 2, 32'h1111_2222, 1, 0, 0, 0, 1);
        vecs[13] = mk("lh b1 mis",   1,0,0,1,12, 0, 1,LT_LH, 1, 32'h1111_2222, 1, 0, 0, 0, 1);
        vecs[14] = mk("reserved",    1,0,0,1,13, 0, 1,3'd7,  0, 32'h1111_2222, 1, 0, 0, 0, 1);
        vecs[15] = mk("lbu nowd",    1,0,0,0,14, 0, 1,LT_LBU,0, 32'h0000_00FF, 1, 0, 0, 0, 0);
        vecs[16] = mk("load flush",  1,0,1,1,15, 0, 1,LT_LW, 0, 32'h5555_5555, 1, 0, 0, 0, 0);

        // Reset state
        idle();
        tick();
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        check_out("post reset", 0, 0, 0, 0, 0, 0);

        // Single-cycle vector table
        foreach (vecs[i]) begin
            drive_run(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].wdf,
                      vecs[i].waddr, vecs[i].wdat, vecs[i].load, vecs[i].lt,
                      vecs[i].lo, vecs[i].rdata, vecs[i].ok);
            tick();
            check_out(vecs[i].name, vecs[i].exp_wd, vecs[i].exp_addr,
                      vecs[i].exp_data, vecs[i].exp_mis, 0, 0);
        end
        idle();

        // ALU write is a single-cycle pulse
        drive_run(1,0,0,1, 5, 32'h1234, 0,0,0, 0, 0);
        tick();
        check_out("alu pulse", 1, 5, 32'h1234, 0, 0, 0);
        idle();
        tick();
        check_out("alu after", 0, 0, 0, 0, 0, 0);

        // LB b=2, data three cycles after capture
        drive_run(1,0,0,1, 17, 0, 1, LT_LB, 2, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            junk();
            if (k == 2) begin dm_data_ok = 1; dm_rdata = 32'h0080_0000; end
            if (k > 0) check_out("lb wait busy", 0, 0, 0, 0, 0, 1);
            else       check_out("lb capture", 0, 0, 0, 0, 0, 1);
            tick();
        end
        check_out("lb done", 1, 17, 32'hFFFF_FF80, 0, 0, 0);
        idle();

        // LW b=1 delayed: misalign pulses once at completion
        drive_run(1,0,0,1, 18, 0, 1, LT_LW, 1, 0, 0);
        tick();
        junk(); dm_data_ok = 1;
        tick();
        check_out("lw mis done", 0, 0, 0, 1, 0, 0);
        idle();
        tick();
        check_out("lw mis after", 0, 0, 0, 0, 0, 0);

        // Flush in WAIT -> DRAIN; next response discarded
        drive_run(1,0,0,1, 19, 0, 1, LT_LW, 0, 0, 0);
        tick();
        idle(); flush_i = 1;
        tick();
        check_out("drain entry", 0, 0, 0, 0, 0, 1);
        idle(); flush_i = 1;
        tick();
        check_out("drain flush ignored", 0, 0, 0, 0, 0, 1);
        idle(); dm_data_ok = 1; dm_rdata = 32'h0000_DEAD;
        tick();
        check_out("drain discard", 0, 0, 0, 0, 0, 0);
        drive_run(1,0,0,1, 20, 32'h0BAD_F00D, 0,0,0, 32'h0000_DEAD, 1);
        tick();
        check_out("alu after drain", 1, 20, 32'h0BAD_F00D, 0, 0, 0);
        idle();

        // Timeout: bus_err exactly TIMEOUT cycles after capture
        drive_run(1,0,0,1, 21, 0, 1, LT_LW, 0, 0, 0);
        tick();
        idle();
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk("timeout busy", mif.wb_busy, 1);
            chk("timeout early err", bus_err_o, 0);
        end
        tick();
        check_out("timeout", 0, 0, 0, 0, 1, 0);
        tick();
        check_out("timeout after", 0, 0, 0, 0, 0, 0);

        // Response on the last WAIT cycle still completes
        drive_run(1,0,0,1, 22, 0, 1, LT_LW, 0, 0, 0);
        tick();
        idle();
        for (int k = 1; k < TIMEOUT; k++) tick();
        dm_data_ok = 1; dm_rdata = 32'h7654_3210;
        tick();
        check_out("late data", 1, 22, 32'h7654_3210, 0, 0, 0);
        idle();

        // Asynchronous reset while waiting
        drive_run(1,0,0,1, 23, 0, 1, LT_LW, 0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        last_addr = '0;
        last_data = '0;
        check_out("async reset", 0, 0, 0, 0, 0, 0);
        #3 rst = 1'b1;
        tick();
        drive_run(1,0,0,1, 24, 32'h00C0_FFEE, 0,0,0, 0, 0);
        tick();
        check_out("alu after reset", 1, 24, 32'h00C0_FFEE, 0, 0, 0);
        idle();

        // Randomized transactions against the transaction-level model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                logic v, st, fl, wf, ld, bub, ewd;
                logic [4:0] wa;
                logic [31:0] wdt;
                v = ($urandom_range(0, 7) != 0);
                st = ($urandom_range(0, 7) == 0);
                fl = ($urandom_range(0, 7) == 0);
                wf = 1'($urandom);
                wa = 5'($urandom);
                wdt = $urandom;
                bub = !v || st || fl;
                ld = bub ? 1'($urandom) : 1'b0;
                drive_run(v, st, fl, wf, wa, wdt, ld, 3'($urandom), 2'($urandom),
                          $urandom, 1'($urandom));
                tick();
                ewd = !bub && wf;
                check_out("rnd alu", ewd, wa, wdt, 0, 0, 0);
            end else begin
                int d, fm, lt, lo;
                logic lwd;
                logic [4:0] la;
                logic [31:0] rd;
                bit flushed;
                d = $urandom_range(0, 4);
                fm = $urandom_range(0, 5);
                if (fm == 0 && d < 2) fm = 5;
                if (fm == 1 && d < 1) fm = 5;
                lt = $urandom_range(0, 7);
                lo = $urandom_range(0, 3);
                rd = $urandom;
                lwd = ($urandom_range(0, 5) != 0);
                la = 5'($urandom);
                drive_run(1, 0, 0, lwd, la, $urandom, 1, 3'(lt), 2'(lo), rd, d == 0);
                tick();
                if (d > 0) begin
                    check_out("rnd capture", 0, 0, 0, 0, 0, 1);
                    for (int i = 1; i <= d; i++) begin
                        junk();
                        if (i == d) begin
                            dm_data_ok = 1;
                            dm_rdata = (fm == 0) ? $urandom : rd;
                            flush_i = (fm == 1);
                        end else if (fm == 0) begin
                            flush_i = (i == 1) ? 1'b1 : 1'($urandom);
                        end
                        tick();
                        if (i < d) check_out("rnd busy", 0, 0, 0, 0, 0, 1);
                    end
                end
                flushed = (fm <= 1);
                ref_load(lt, lo, rd, ev, emis);
                if (flushed)   check_out("rnd load flushed", 0, 0, 0, 0, 0, 0);
                else if (emis) check_out("rnd load mis", 0, 0, 0, 1, 0, 0);
                else           check_out("rnd load", lwd, la, ev, 0, 0, 0);
            end
            idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
